muldiv_unit: RTL and testbench

//  EX-stage multiply/divide unit with HI/LO registers. Consumes MULDIVMode/HILOSel

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Optional MULDIV_FLUSH_EN macro adds a Flush input that aborts an operation in flight.
module muldiv_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
`ifdef MULDIV_FLUSH_EN
   input  logic        Flush,
`endif
   input  logic [3:0]  MULDIVMode,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HILOSel,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MULDIVOut
);

   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic [CW-1:0]  r_count;
   logic [31:0]    r_shHi;
   logic [31:0]    r_shLo;
   logic           r_shWrite;
   logic [31:0]    r_hi;
   logic [31:0]    r_lo;

   logic           w_flush;
   logic           w_launch;
   logic           w_commit;
   logic           w_mtHi;
   logic           w_mtLo;
   logic           w_isMul;
   logic           w_isDiv;
   logic           w_lastCycle;
   logic [63:0]    w_mulS;
   logic [63:0]    w_mulU;
   logic [31:0]    w_absA;
   logic [31:0]    w_absB;
   logic [31:0]    w_uq;
   logic [31:0]    w_ur;
   logic [31:0]    w_resHi;
   logic [31:0]    w_resLo;

`ifdef MULDIV_FLUSH_EN
   assign w_flush = Flush;
`else
   assign w_flush = 1'b0;
`endif

   assign w_isMul     = (MULDIVMode == 4'd0) || (MULDIVMode == 4'd1);
   assign w_isDiv     = (MULDIVMode == 4'd2) || (MULDIVMode == 4'd3);
   assign w_lastCycle = (r_count == CW'(1));

   // Signed product taken as the low 64 bits of the sign-extended operands' product.
   assign w_mulS = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign w_mulU = {32'b0, A} * {32'b0, B};

   // Signed divide done on magnitudes so INT_MIN / -1 wraps to INT_MIN with remainder 0.
   assign w_absA = A[31] ? (~A + 32'd1) : A;
   assign w_absB = B[31] ? (~B + 32'd1) : B;
   assign w_uq   = w_absA / w_absB;
   assign w_ur   = w_absA % w_absB;

   always_comb begin
      w_resHi = 32'd0;
      w_resLo = 32'd0;
      case (MULDIVMode)
         4'd0: begin
            w_resHi = w_mulS[63:32];
            w_resLo = w_mulS[31:0];
         end
         4'd1: begin
            w_resHi = w_mulU[63:32];
            w_resLo = w_mulU[31:0];
         end
         4'd2: begin
            w_resLo = (A[31] ^ B[31]) ? (~w_uq + 32'd1) : w_uq;
            w_resHi = A[31] ? (~w_ur + 32'd1) : w_ur;
         end
         4'd3: begin
            w_resLo = A / B;
            w_resHi = A % B;
         end
         default: begin
            w_resHi = 32'd0;
            w_resLo = 32'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: if (w_launch) w_nextState = RUN;
         RUN:  if (w_flush || w_lastCycle) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      w_launch = 1'b0;
      w_mtHi   = 1'b0;
      w_mtLo   = 1'b0;
      w_commit = 1'b0;
      Busy     = 1'b0;
      case (r_state)
         IDLE: begin
            w_launch = Start && !w_flush && (w_isMul || w_isDiv);
            w_mtHi   = Start && !w_flush && (MULDIVMode == 4'd4);
            w_mtLo   = Start && !w_flush && (MULDIVMode == 4'd5);
         end
         RUN: begin
            Busy     = 1'b1;
            w_commit = !w_flush && w_lastCycle;
         end
         default: Busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count   <= '0;
         r_shHi    <= 32'd0;
         r_shLo    <= 32'd0;
         r_shWrite <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
      end else begin
         if (w_launch) begin
            r_count   <= w_isMul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
            r_shHi    <= w_resHi;
            r_shLo    <= w_resLo;
            r_shWrite <= !(w_isDiv && (B == 32'd0));
         end else if (w_flush) begin
            r_count <= '0;
         end else if (r_state == RUN) begin
            r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
         end
         if (w_commit && r_shWrite) begin
            r_hi <= r_shHi;
            r_lo <= r_shLo;
         end
         if (w_mtHi) r_hi <= A;
         if (w_mtLo) r_lo <= A;
      end
   end

   assign HI        = r_hi;
   assign LO        = r_lo;
   assign MULDIVOut = HILOSel ? r_hi : r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit: randomized ops checked against a plain-arithmetic model.
// Exercises the Flush path as well when MULDIV_FLUSH_EN is defined.
module tb_muldiv_unit;

   localparam int MULC = 5;
   localparam int DIVC = 10;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        Start = 1'b0;
   logic [3:0]  MULDIVMode = 4'd0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        HILOSel = 1'b0;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MULDIVOut;
`ifdef MULDIV_FLUSH_EN
   logic        Flush = 1'b0;
`endif

   exp_t        sb[$];
   int          testsRun = 0;
   int          testsFailed = 0;
   logic [31:0] mHi = 32'd0;
   logic [31:0] mLo = 32'd0;
   logic [31:0] pHi = 32'd0;
   logic [31:0] pLo = 32'd0;
   logic        sawImm = 1'b0;
   logic        prevBusy = 1'b0;
   int          busyCnt = 0;

   muldiv_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
      .clk       (clk),
      .reset     (reset),
      .Start     (Start),
`ifdef MULDIV_FLUSH_EN
      .Flush     (Flush),
`endif
      .MULDIVMode(MULDIVMode),
      .A         (A),
      .B         (B),
      .HILOSel   (HILOSel),
      .Busy      (Busy),
      .HI        (HI),
      .LO        (LO),
      .MULDIVOut (MULDIVOut)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      testsRun++;
      if (act !== req) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference model: architectural effect of one op on HI/LO plus its busy length.
   task automatic modelOp(input logic [3:0] mode, input logic [31:0] a, input logic [31:0] b,
                          inout logic [31:0] hi, inout logic [31:0] lo, output int lat);
      longint          sp, sa, sbv, q, r;
      longint unsigned up;
      lat = 0;
      case (mode)
         4'd0: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            hi = sp[63:32];
            lo = sp[31:0];
            lat = MULC;
         end
         4'd1: begin
            up = longint'(a) * longint'(b);
            hi = up[63:32];
            lo = up[31:0];
            lat = MULC;
         end
         4'd2: begin
            if (b != 0) begin
               sa  = longint'($signed(a));
               sbv = longint'($signed(b));
               q = sa / sbv;
               r = sa % sbv;
               lo = q[31:0];
               hi = r[31:0];
            end
            lat = DIVC;
         end
         4'd3: begin
            if (b != 0) begin
               lo = a / b;
               hi = a % b;
            end
            lat = DIVC;
         end
         4'd4: hi = a;
         4'd5: lo = a;
         default: ;
      endcase
   endtask

   task automatic applyStimulus(input logic [3:0] mode, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   guard;
      @(negedge clk);
      e.hi = pHi;
      e.lo = pLo;
      modelOp(mode, a, b, e.hi, e.lo, e.lat);
      pHi = e.hi;
      pLo = e.lo;
      sb.push_back(e);
      MULDIVMode = mode;
      A = a;
      B = b;
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      A = $urandom;
      B = $urandom;
      guard = 0;
      while ((sb.size() != 0 || Busy) && guard < 60) begin
         @(negedge clk);
         HILOSel = 1'($urandom);
         #1;
         guard++;
      end
      if (guard >= 60) begin
         checkOutput("completion_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   always @(posedge clk) begin
      sawImm = reset && Start && !Busy && (MULDIVMode >= 4'd4)
`ifdef MULDIV_FLUSH_EN
               && !Flush
`endif
               ;
   end

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (!reset) begin
         prevBusy = 1'b0;
         busyCnt  = 0;
         sawImm   = 1'b0;
      end else begin
         if (sawImm) begin
            sawImm = 1'b0;
            if (sb.size() == 0) begin
               checkOutput("unexpected_imm", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("imm_busy", 32'(Busy), 32'd0);
               checkOutput("imm_hi", HI, e.hi);
               checkOutput("imm_lo", LO, e.lo);
               mHi = e.hi;
               mLo = e.lo;
            end
         end
         if (Busy) begin
            busyCnt++;
         end else if (prevBusy) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("busy_len", 32'(busyCnt), 32'(e.lat));
               checkOutput("done_hi", HI, e.hi);
               checkOutput("done_lo", LO, e.lo);
               mHi = e.hi;
               mLo = e.lo;
            end
            busyCnt = 0;
         end
         prevBusy = Busy;
         checkOutput("muldivout", MULDIVOut, HILOSel ? mHi : mLo);
      end
   end

   initial begin
      logic [3:0]  mode;
      logic [31:0] a, b;
      int          sel;
      $display("[TB] muldiv_unit test start");
      #1;
      checkOutput("reset_busy", 32'(Busy), 32'd0);
      checkOutput("reset_hi", HI, 32'd0);
      checkOutput("reset_lo", LO, 32'd0);
      checkOutput("reset_out", MULDIVOut, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      applyStimulus(4'd0, 32'hFFFFFFFE, 32'd3);
      checkOutput("mult_hi_const", HI, 32'hFFFFFFFF);
      checkOutput("mult_lo_const", LO, 32'hFFFFFFFA);
      applyStimulus(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      checkOutput("multu_hi_const", HI, 32'hFFFFFFFE);
      checkOutput("multu_lo_const", LO, 32'h00000001);
      applyStimulus(4'd2, 32'hFFFFFFF9, 32'd2);
      checkOutput("div_lo_const", LO, 32'hFFFFFFFD);
      checkOutput("div_hi_const", HI, 32'hFFFFFFFF);
      applyStimulus(4'd3, 32'd7, 32'd0);
      checkOutput("divu0_lo_const", LO, 32'hFFFFFFFD);
      checkOutput("divu0_hi_const", HI, 32'hFFFFFFFF);
      applyStimulus(4'd2, 32'h80000000, 32'hFFFFFFFF);
      checkOutput("divovf_lo_const", LO, 32'h80000000);
      checkOutput("divovf_hi_const", HI, 32'h00000000);
      applyStimulus(4'd5, 32'hCAFEF00D, 32'd0);
      applyStimulus(4'd4, 32'h12345678, 32'd0);
      checkOutput("mthi_hi_const", HI, 32'h12345678);
      checkOutput("mthi_lo_const", LO, 32'hCAFEF00D);
      applyStimulus(4'd9, 32'h55555555, 32'h1);

      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 19));
         if (sel < 14)      mode = 4'(sel % 4);
         else if (sel < 17) mode = 4'(4 + sel % 2);
         else               mode = 4'($urandom_range(6, 15));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFFFFFF;
            2: a = 32'h80000000;
            3: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         applyStimulus(mode, a, b);
      end

`ifdef MULDIV_FLUSH_EN
      begin
         exp_t e;
         applyStimulus(4'd4, 32'hAAAA0001, 32'd0);
         applyStimulus(4'd5, 32'hBBBB0002, 32'd0);
         @(negedge clk);
         e.hi = pHi;
         e.lo = pLo;
         e.lat = 2;
         sb.push_back(e);
         MULDIVMode = 4'd0;
         A = 32'd2;
         B = 32'd3;
         Start = 1'b1;
         @(negedge clk);
         Start = 1'b0;
         @(negedge clk);
         Flush = 1'b1;
         @(negedge clk);
         Flush = 1'b0;
         checkOutput("flush_busy", 32'(Busy), 32'd0);
         repeat (MULC + 2) @(negedge clk);
         checkOutput("flush_hi", HI, 32'hAAAA0001);
         checkOutput("flush_lo", LO, 32'hBBBB0002);
         @(negedge clk);
         MULDIVMode = 4'd4;
         A = 32'h0BAD0BAD;
         Start = 1'b1;
         Flush = 1'b1;
         @(negedge clk);
         Start = 1'b0;
         Flush = 1'b0;
         checkOutput("flush_mthi_hi", HI, 32'hAAAA0001);
         checkOutput("flush_mthi_busy", 32'(Busy), 32'd0);
      end
`endif

      applyStimulus(4'd0, 32'd1234, 32'd5678);
      applyStimulus(4'd2, 32'd1000, 32'd7);
      @(negedge clk);
      MULDIVMode = 4'd2;
      A = 32'd99;
      B = 32'd4;
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      repeat (2) @(negedge clk);
      #3;
      reset = 1'b0;
      #1;
      checkOutput("async_rst_busy", 32'(Busy), 32'd0);
      checkOutput("async_rst_hi", HI, 32'd0);
      checkOutput("async_rst_lo", LO, 32'd0);
      sb.delete();
      mHi = 32'd0;
      mLo = 32'd0;
      pHi = 32'd0;
      pLo = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < DIVC + 3; i++) begin
         @(negedge clk);
         HILOSel = 1'($urandom);
      end
      #3;
      checkOutput("post_rst_busy", 32'(Busy), 32'd0);
      checkOutput("post_rst_hi", HI, 32'd0);
      checkOutput("post_rst_lo", LO, 32'd0);
      checkOutput("post_rst_sb", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
